// File: rtl/isp_pkg.sv
// Shared ISP helpers: output saturation, identity coefficient bank and coefficient slot map.
package isp_pkg;

   localparam int MAXW = 64;

   typedef struct packed {
      logic [MAXW-1:0] val;
      logic            sat;
   } sat_t;

   // CW-wide slot of c<row><col> on a row-major coefficient bus, c11 in the top slot.
   localparam int CSLOT [3][3] = '{'{8, 7, 6}, '{5, 4, 3}, '{2, 1, 0}};

   function automatic logic [9*MAXW-1:0] ident_bank(input int cw, input int frac);
      logic [9*MAXW-1:0] b;
      b = '0;
      for (int k = 0; k < 9; k++) begin
         b = b << cw;
         if (k == 0 || k == 4 || k == 8)
            b[MAXW-1:0] = b[MAXW-1:0] | (MAXW'(1) << frac);
      end
      return b;
   endfunction

   function automatic sat_t sat_signed(input logic signed [MAXW-1:0] v, input int ow);
      logic signed [MAXW-1:0] hi, lo;
      sat_t r;
      hi    = $signed((MAXW'(1) << (ow - 1)) - MAXW'(1));
      lo    = ~hi;
      r.sat = (v > hi) || (v < lo);
      r.val = (v > hi) ? hi : ((v < lo) ? lo : v);
      return r;
   endfunction

   function automatic sat_t sat_unsigned(input logic signed [MAXW-1:0] v, input int ow);
      logic signed [MAXW-1:0] hi;
      sat_t r;
      hi    = $signed((MAXW'(1) << ow) - MAXW'(1));
      r.sat = v[MAXW-1] || (v > hi);
      r.val = v[MAXW-1] ? '0 : ((v > hi) ? hi : v);
      return r;
   endfunction

endpackage

// File: rtl/ccm_row_mac.sv
// One matrix row: S2 products, S3 row sum, S4 round/shift/saturate; en=0 freezes every register.
// The S4 result only loads for a valid beat, so res/sat hold across bubbles.
module ccm_row_mac
   import isp_pkg::*;
#(
   parameter int DW           = 18,
   parameter int CW           = 18,
   parameter int FRAC         = 10,
   parameter int OW           = 18,
   parameter int OUT_UNSIGNED = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 vld3,
   input  logic signed [DW-1:0] x,
   input  logic signed [DW-1:0] y,
   input  logic signed [DW-1:0] z,
   input  logic signed [CW-1:0] c0,
   input  logic signed [CW-1:0] c1,
   input  logic signed [CW-1:0] c2,
   output logic [OW-1:0]        res,
   output logic                 sat
);

   localparam int PW  = DW + CW;
   localparam int AW  = PW + 2;
   localparam int AW1 = AW + 1;
   localparam logic signed [AW:0] RND = (AW1'(1) << FRAC) >> 1;

   logic signed [PW-1:0] p0, p1, p2;
   logic signed [AW-1:0] acc;
   logic signed [AW:0]   rnd, shf;
   sat_t                 clamp;
   logic                 unused_hi;

   always_comb begin
      rnd   = {acc[AW-1], acc} + RND;
      shf   = rnd >>> FRAC;
      clamp = (OUT_UNSIGNED != 0) ? sat_unsigned(MAXW'(shf), OW) : sat_signed(MAXW'(shf), OW);
   end

   assign unused_hi = ^clamp.val[MAXW-1:OW];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p0  <= '0;
         p1  <= '0;
         p2  <= '0;
         acc <= '0;
         res <= '0;
         sat <= 1'b0;
      end else if (en) begin
         p0  <= PW'(x) * PW'(c0);
         p1  <= PW'(y) * PW'(c1);
         p2  <= PW'(z) * PW'(c2);
         acc <= AW'(p0) + AW'(p1) + AW'(p2);
         if (vld3) begin
            res <= clamp.val[OW-1:0];
            sat <= clamp.sat;
         end
      end
   end

endmodule

// File: rtl/ccm_matrix_pipe.sv
// 3x3 signed colour matrix, out = C x in, 4-cycle latency at 1 beat/clk, per-frame double-buffered coefficients.
// No backpressure: en=0 freezes all stages and a beat offered while en=0 is dropped.
module ccm_matrix_pipe
   import isp_pkg::*;
#(
   parameter int DW           = 18,
   parameter int CW           = 18,
   parameter int FRAC         = 10,
   parameter int OW           = 18,
   parameter int OUT_UNSIGNED = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            in_valid,
   input  logic            in_sof,
   input  logic [3*DW-1:0] in_data,
   input  logic            coef_wr,
   input  logic [9*CW-1:0] coef_in,
   input  logic            bypass,
   output logic            out_valid,
   output logic            out_sof,
   output logic [3*OW-1:0] out_data,
   output logic [2:0]      out_sat,
   output logic            coef_pending
);

   localparam logic [9*MAXW-1:0] IDENT_W = ident_bank(CW, FRAC);
   localparam logic [9*CW-1:0]   IDENT   = IDENT_W[9*CW-1:0];

   logic [9*CW-1:0] active, shadow, beat_coef, s1_coef;
   logic [3*DW-1:0] s1_data;
   logic            sof_go;
   logic            s1_vld, s1_sof, s2_vld, s2_sof, s3_vld, s3_sof;

   assign sof_go = in_valid & in_sof & en;

   // Bypass rides the identity matrix: x*2^FRAC plus the half-LSB round shifts back to exactly x.
   always_comb begin
      beat_coef = active;
      if (bypass)
         beat_coef = IDENT;
      else if (sof_go)
         beat_coef = coef_wr ? coef_in : shadow;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active       <= IDENT;
         shadow       <= IDENT;
         coef_pending <= 1'b0;
      end else begin
         if (coef_wr)
            shadow <= coef_in;
         if (sof_go) begin
            active       <= coef_wr ? coef_in : shadow;
            coef_pending <= 1'b0;
         end else if (coef_wr) begin
            coef_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld    <= 1'b0;
         s1_sof    <= 1'b0;
         s1_data   <= '0;
         s1_coef   <= '0;
         s2_vld    <= 1'b0;
         s2_sof    <= 1'b0;
         s3_vld    <= 1'b0;
         s3_sof    <= 1'b0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
      end else if (en) begin
         s1_vld    <= in_valid;
         s1_sof    <= in_valid & in_sof;
         s1_data   <= in_data;
         s1_coef   <= beat_coef;
         s2_vld    <= s1_vld;
         s2_sof    <= s1_sof;
         s3_vld    <= s2_vld;
         s3_sof    <= s2_sof;
         out_valid <= s3_vld;
         out_sof   <= s3_sof;
      end
   end

   for (genvar r = 0; r < 3; r++) begin : g_row
      ccm_row_mac #(
         .DW(DW), .CW(CW), .FRAC(FRAC), .OW(OW), .OUT_UNSIGNED(OUT_UNSIGNED)
      ) u_row (
         .clk   (clk),
         .reset (reset),
         .en    (en),
         .vld3  (s3_vld),
         .x     (s1_data[2*DW +: DW]),
         .y     (s1_data[DW +: DW]),
         .z     (s1_data[0 +: DW]),
         .c0    (s1_coef[CSLOT[r][0]*CW +: CW]),
         .c1    (s1_coef[CSLOT[r][1]*CW +: CW]),
         .c2    (s1_coef[CSLOT[r][2]*CW +: CW]),
         .res   (out_data[(2-r)*OW +: OW]),
         .sat   (out_sat[2-r])
      );
   end

endmodule

// File: tb/tb_ccm_matrix_pipe.sv
module tb_ccm_matrix_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   // default-parameter instance
   logic         d_en, d_iv, d_sof, d_cwr, d_byp;
   logic [53:0]  d_data;
   logic [161:0] d_cin;
   logic         d_ov, d_osof, d_pend;
   logic [53:0]  d_od;
   logic [2:0]   d_osat;

   // OW=10 signed (s_) and unsigned (u_) instances share one stimulus set
   logic         g_en, g_iv, g_sof, g_cwr, g_byp;
   logic [53:0]  g_data;
   logic [161:0] g_cin;
   logic         s_ov, s_osof, s_pend, u_ov, u_osof, u_pend;
   logic [29:0]  s_od, u_od;
   logic [2:0]   s_osat, u_osat;

   typedef struct {
      logic [53:0] d;
      logic [2:0]  sat;
      logic        sof;
   } exp_t;

   exp_t q_d[$], q_s[$], q_u[$];
   int checks = 0;
   int passes = 0;

   ccm_matrix_pipe u_dut (
      .clk(clk), .reset(reset), .en(d_en), .in_valid(d_iv), .in_sof(d_sof), .in_data(d_data),
      .coef_wr(d_cwr), .coef_in(d_cin), .bypass(d_byp), .out_valid(d_ov), .out_sof(d_osof),
      .out_data(d_od), .out_sat(d_osat), .coef_pending(d_pend));

   ccm_matrix_pipe #(.OW(10), .OUT_UNSIGNED(0)) u_dut_s (
      .clk(clk), .reset(reset), .en(g_en), .in_valid(g_iv), .in_sof(g_sof), .in_data(g_data),
      .coef_wr(g_cwr), .coef_in(g_cin), .bypass(g_byp), .out_valid(s_ov), .out_sof(s_osof),
      .out_data(s_od), .out_sat(s_osat), .coef_pending(s_pend));

   ccm_matrix_pipe #(.OW(10), .OUT_UNSIGNED(1)) u_dut_u (
      .clk(clk), .reset(reset), .en(g_en), .in_valid(g_iv), .in_sof(g_sof), .in_data(g_data),
      .coef_wr(g_cwr), .coef_in(g_cin), .bypass(g_byp), .out_valid(u_ov), .out_sof(u_osof),
      .out_data(u_od), .out_sat(u_osat), .coef_pending(u_pend));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   function automatic logic [53:0] v18(input int a, input int b, input int c);
      return {18'(a), 18'(b), 18'(c)};
   endfunction

   function automatic logic [53:0] v10(input int a, input int b, input int c);
      return {24'd0, 10'(a), 10'(b), 10'(c)};
   endfunction

   function automatic logic [161:0] diag(input int v);
      logic [17:0] k, z;
      k = 18'(v);
      z = '0;
      return {k, z, z, z, k, z, z, z, k};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic d_beat(input int x, input int y, input int z, input logic sof, input logic byp,
                         input int a, input int b, input int c, input logic [2:0] sat);
      exp_t e;
      d_iv = 1'b1; d_sof = sof; d_byp = byp; d_data = v18(x, y, z);
      e.d = v18(a, b, c); e.sat = sat; e.sof = sof;
      q_d.push_back(e);
      cyc();
      d_iv = 1'b0; d_sof = 1'b0; d_byp = 1'b0; d_cwr = 1'b0;
   endtask

   task automatic g_beat(input int x, input int y, input int z, input logic sof, input logic byp,
                         input int sa, input int sb, input int sc, input logic [2:0] ssat,
                         input int ua, input int ub, input int uc, input logic [2:0] usat);
      exp_t e;
      g_iv = 1'b1; g_sof = sof; g_byp = byp; g_data = v18(x, y, z);
      e.d = v10(sa, sb, sc); e.sat = ssat; e.sof = sof;
      q_s.push_back(e);
      e.d = v10(ua, ub, uc); e.sat = usat;
      q_u.push_back(e);
      cyc();
      g_iv = 1'b0; g_sof = 1'b0; g_byp = 1'b0; g_cwr = 1'b0;
   endtask

   // Monitors: an output is consumed on each cycle it is valid while the pipe advances.
   always @(negedge clk) begin : mon_d
      exp_t e;
      if (!reset && d_ov && d_en) begin
         if (q_d.size() == 0) chk("d_extra_output", 64'(1), 64'(0));
         else begin
            e = q_d.pop_front();
            chk("d_data", 64'(d_od), 64'(e.d));
            chk("d_sat", 64'(d_osat), 64'(e.sat));
            chk("d_sof", 64'(d_osof), 64'(e.sof));
         end
      end
   end

   always @(negedge clk) begin : mon_s
      exp_t e;
      if (!reset && s_ov && g_en) begin
         if (q_s.size() == 0) chk("s_extra_output", 64'(1), 64'(0));
         else begin
            e = q_s.pop_front();
            chk("s_data", 64'(s_od), 64'(e.d));
            chk("s_sat", 64'(s_osat), 64'(e.sat));
            chk("s_sof", 64'(s_osof), 64'(e.sof));
         end
      end
   end

   always @(negedge clk) begin : mon_u
      exp_t e;
      if (!reset && u_ov && g_en) begin
         if (q_u.size() == 0) chk("u_extra_output", 64'(1), 64'(0));
         else begin
            e = q_u.pop_front();
            chk("u_data", 64'(u_od), 64'(e.d));
            chk("u_sat", 64'(u_osat), 64'(e.sat));
            chk("u_sof", 64'(u_osof), 64'(e.sof));
         end
      end
   end

   initial begin : stim
      int i;
      reset = 1'b1;
      d_en = 1'b1; d_iv = 1'b0; d_sof = 1'b0; d_cwr = 1'b0; d_byp = 1'b0; d_data = '0; d_cin = '0;
      g_en = 1'b1; g_iv = 1'b0; g_sof = 1'b0; g_cwr = 1'b0; g_byp = 1'b0; g_data = '0; g_cin = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(d_ov), 64'(0));
      chk("rst_out_sof", 64'(d_osof), 64'(0));
      chk("rst_out_data", 64'(d_od), 64'(0));
      chk("rst_out_sat", 64'(d_osat), 64'(0));
      chk("rst_coef_pending", 64'(d_pend), 64'(0));
      reset = 1'b0;
      cyc();

      // identity after reset, exact latency and single-cycle valid
      d_beat(100, 200, -300, 1'b1, 1'b0, 100, 200, -300, 3'b000);
      chk("lat_c1", 64'(d_ov), 64'(0)); cyc();
      chk("lat_c2", 64'(d_ov), 64'(0)); cyc();
      chk("lat_c3", 64'(d_ov), 64'(0)); cyc();
      chk("lat_c4", 64'(d_ov), 64'(1)); cyc();
      chk("lat_c5", 64'(d_ov), 64'(0));
      chk("data_hold", 64'(d_od), 64'(v18(100, 200, -300)));

      // coef_wr together with sof loads active directly; 0.5 gain rounds half up
      d_cwr = 1'b1; d_cin = diag(512);
      d_beat(3, -3, 1, 1'b1, 1'b0, 2, -1, 1, 3'b000);
      chk("pend_wr_with_sof", 64'(d_pend), 64'(0));

      // mid-frame shadow write, swap at next sof, in-flight beat keeps old gain
      d_beat(10, 10, 10, 1'b0, 1'b0, 5, 5, 5, 3'b000);
      d_cwr = 1'b1; d_cin = diag(2048);
      cyc();
      d_cwr = 1'b0;
      chk("pend_set", 64'(d_pend), 64'(1));
      d_beat(10, 10, 10, 1'b0, 1'b0, 5, 5, 5, 3'b000);
      d_beat(6, 6, 6, 1'b0, 1'b0, 3, 3, 3, 3'b000);
      d_beat(10, 10, 10, 1'b1, 1'b0, 20, 20, 20, 3'b000);
      chk("pend_clr", 64'(d_pend), 64'(0));
      repeat (6) cyc();

      // 8-beat stream with en low for three cycles; coef_wr accepted during the stall
      i = 1;
      for (int c = 0; i <= 8; c++) begin
         d_en = !(c >= 3 && c <= 5);
         d_iv = 1'b1; d_sof = 1'b0; d_data = v18(i, -i, 2 * i);
         d_cwr = (c == 4); d_cin = diag(1024);
         if (d_en) begin
            q_d.push_back('{d: v18(2 * i, -2 * i, 4 * i), sat: 3'b000, sof: 1'b0});
            i++;
         end
         cyc();
      end
      d_iv = 1'b0; d_cwr = 1'b0; d_en = 1'b1;
      chk("pend_stall_wr", 64'(d_pend), 64'(1));
      d_beat(5, 6, 7, 1'b1, 1'b0, 5, 6, 7, 3'b000);
      chk("pend_clr_stall", 64'(d_pend), 64'(0));
      repeat (6) cyc();

      // asynchronous reset with three beats in flight
      d_cwr = 1'b1; d_cin = diag(2048);
      d_beat(1, 1, 1, 1'b1, 1'b0, 2, 2, 2, 3'b000);
      d_beat(2, 2, 2, 1'b0, 1'b0, 4, 4, 4, 3'b000);
      d_cwr = 1'b1; d_cin = diag(512);
      d_beat(3, 3, 3, 1'b0, 1'b0, 6, 6, 6, 3'b000);
      d_beat(4, 4, 4, 1'b0, 1'b0, 8, 8, 8, 3'b000);
      d_beat(5, 5, 5, 1'b0, 1'b0, 10, 10, 10, 3'b000);
      chk("pre_reset_valid", 64'(d_ov), 64'(1));
      chk("pre_reset_pend", 64'(d_pend), 64'(1));
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 64'(d_ov), 64'(0));
      chk("async_rst_data", 64'(d_od), 64'(0));
      chk("async_rst_pend", 64'(d_pend), 64'(0));
      q_d.delete();
      cyc();
      reset = 1'b0;
      cyc();
      d_beat(7, 8, 9, 1'b1, 1'b0, 7, 8, 9, 3'b000);
      repeat (8) cyc();

      // saturation and bypass on the 10-bit signed / unsigned instances, gain 2.0
      g_cwr = 1'b1; g_cin = diag(2048);
      g_beat(600, -5, 0, 1'b1, 1'b0, 511, -10, 0, 3'b100, 1023, 0, 0, 3'b110);
      g_beat(-7, 5, 9, 1'b0, 1'b1, -7, 5, 9, 3'b000, 0, 5, 9, 3'b100);
      g_beat(600, -600, 1000, 1'b0, 1'b1, 511, -512, 511, 3'b111, 600, 0, 1000, 3'b010);
      g_beat(100, -100, 3, 1'b0, 1'b0, 200, -200, 6, 3'b000, 200, 0, 6, 3'b010);
      repeat (8) cyc();

      chk("q_d_drained", 64'(q_d.size()), 64'(0));
      chk("q_s_drained", 64'(q_s.size()), 64'(0));
      chk("q_u_drained", 64'(q_u.size()), 64'(0));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ccm_matrix_pipe.md
Name: ccm_matrix_pipe

Overview:
- Parametrised, pipelined 3x3 signed matrix-vector multiplier for colour-space and colour-correction stages of the ISP pixel pipeline.
- Computes out = C x in per pixel, with per-frame double-buffered coefficients, rounding, fractional shift, saturation, bypass and a global stall.
- Sits between demosaic and gamma.

Parameters:
- DW, 18: signed input component width.
- CW, 18: signed coefficient width.
- FRAC, 10: fractional bits in coefficients; 1.0 = 2^FRAC.
- OW, 18: output component width.
- OUT_UNSIGNED, 0: 1 clamps outputs to [0, 2^OW-1]; 0 clamps to signed [-2^(OW-1), 2^(OW-1)-1].

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  pipeline advance; 0 freezes every stage, including valid and sat.
- in_valid  in  1  pixel beat valid.
- in_sof  in  1  first beat of frame; qualified by in_valid.
- in_data  in  3*DW  {X,Y,Z}, X in MSBs, each signed.
- coef_wr  in  1  one-cycle pulse; loads coef_in into the shadow bank.
- coef_in  in  9*CW  row-major c11..c33, c11 in MSBs.
- bypass  in  1  sampled with the beat; output = input, resized and saturated, still at latency 4.
- out_valid  out  1  result valid.
- out_sof  out  1  delayed in_sof.
- out_data  out  3*OW  {A,B,C} results.
- out_sat  out  3  per-component saturation flag, {A,B,C}.
- coef_pending  out  1  shadow bank holds coefficients not yet applied.

Behaviour:
- Reset, asynchronous: out_valid=0, out_sof=0, out_data=0, out_sat=0, coef_pending=0. Active and shadow banks reset to identity (diagonal 2^FRAC, others 0). All pipeline valid bits clear.
- Pipeline, advancing only when en=1:
  - S1 registers input, bypass and sof, and selects the coefficient bank.
  - S2 forms 9 products, each DW+CW bits signed.
  - S3 adds each row's three products into an accumulator of DW+CW+2 bits.
  - S4 rounds, shifts, saturates and registers the output.
- Latency: exactly 4 advancing cycles from input beat to out_valid. Throughput: 1 beat per clock with en=1.
- Rounding: add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up toward +inf). FRAC=0 means no rounding add.
- Saturation: clamp to the OUT_UNSIGNED range; out_sat[i]=1 when clamping occurred on that beat.
- Bypass path: sign-extend the input component, then apply the same saturation. No rounding.
- Coefficient banks:
  - coef_wr=1 writes shadow and sets coef_pending=1.
  - Active bank is copied from shadow at S1 of a beat with in_valid & in_sof & en; that beat uses the new coefficients, and coef_pending clears.
  - coef_wr in the same cycle as a qualified sof: coef_in goes straight to active and shadow; pending stays 0.
  - coef_wr with en=0 is still accepted, since coef load is independent of the stall.
- Each beat carries its coefficients down the pipe. A bank swap never alters beats already in S2..S4.
- in_valid=0 beats propagate as bubbles. out_data holds its last value when out_valid=0 and is not cleared.
- en=0 with in_valid=1: the beat is dropped, not queued. The upstream stage must honour en.
- Reset mid-frame discards all in-flight beats. No output appears for them.

Decomposition:
- Shared package isp_pkg holds:
  - identity-matrix constant function of CW/FRAC;
  - sat_signed / sat_unsigned functions;
  - coefficient unpack index constants.
- One natural sub-module: ccm_row_mac, a 3-term product, sum and round/saturate row with its own pipeline registers. It is instantiated 3 times; the top owns the banks, valid/sof pipe and bypass mux.

Test Plan (defaults unless noted):
- Identity after reset: in (100, 200, -300) -> 4 cycles later out (100, 200, -300), out_sat=000, out_valid high for exactly 1 cycle.
- Rounding: coef diag 512 (0.5), in (3, -3, 1) -> out (2, -1, 1).
- Saturation:
  - OW=10, OUT_UNSIGNED=1, coef diag 2048, in (600, -5, 0) -> out (1023, 0, 0), out_sat=110.
  - Signed OW=10, in (600, …) -> A=511.
- Coefficient swap: coef_wr diag 2048 mid-frame -> coef_pending=1 and outputs unchanged. The next sof beat (10, 10, 10) -> (20, 20, 20), pending clears. Beats already in flight keep the old coefficients.
- Stall: stream 8 beats with en low on cycles 3-5 -> outputs are identical and in order, each delayed 3 cycles, with no duplicates. Bypass beat in (-7, 5, 9), OUT_UNSIGNED=1 -> (0, 5, 9), sat=100.
- Reset mid-stream: assert reset with 3 beats in flight -> out_valid=0 immediately (asynchronous), and no stale beat emerges after release; banks back to identity.
